uart_word_sender: RTL and testbench

Transmit-side companion to the UART instruction loader. It pops 16-bit words from the outbound FIFO and sends each one over the shared `uart` transmitter as a 4-byte frame: header, high byte, low byte, XOR checksum. It sits between the FIFO read port and the `uart` `transmit`/`tx_byte`/`is_transmitting` handshake, in the `clk_cmt` domain.

---
 rtl/uart_word_sender.sv | 163 ++++++++++++++++
 tb/tb_uart_word_sender.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_sender.sv
// uart_word_sender: pops 16-bit words from the outbound FIFO and sends each
// one through the shared uart transmitter as a 4-byte frame.
// Frame layout: HEADER, word[15:8], word[7:0], chk (XOR of the first three).
// All outputs are flops or state decodes, so there is no input-to-output
// combinational path.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | waiting for enable, a non-empty FIFO and an idle uart
// S_POP        | fifo_rd_en strobe; the word appears on fifo_dout next cycle
// S_LATCH      | capture the word, precompute the checksum, restart byte index
// S_KICK       | one-cycle transmit pulse; tx_byte was loaded on entry
// S_WAIT_BUSY  | waiting for uart to report busy; re-kick the same byte on timeout
// S_WAIT_DONE  | waiting for uart to finish shifting the current byte
module uart_word_sender #(
   parameter logic [7:0]  HEADER       = 8'h80,
   parameter int unsigned BUSY_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        fifo_empty,
   output logic        fifo_rd_en,
   input  logic [15:0] fifo_dout,
   output logic        transmit,
   output logic [7:0]  tx_byte,
   input  logic        is_transmitting,
   output logic        busy,
   output logic [15:0] frames_sent,
   output logic        tx_error
);

   localparam int unsigned CNT_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(BUSY_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_POP       = 3'd1,
      S_LATCH     = 3'd2,
      S_KICK      = 3'd3,
      S_WAIT_BUSY = 3'd4,
      S_WAIT_DONE = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      word_q, word_d;
   logic [7:0]       chk_q, chk_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic [15:0]      frames_sent_q, frames_sent_d;
   logic             tx_error_q, tx_error_d;

   // Byte of the frame addressed by the index.
   function automatic logic [7:0] sel_byte(input logic [1:0]  idx,
                                           input logic [15:0] word,
                                           input logic [7:0]  chk);
      logic [7:0] b;
      case (idx)
         2'd0:    b = HEADER;
         2'd1:    b = word[15:8];
         2'd2:    b = word[7:0];
         default: b = chk;
      endcase
      return b;
   endfunction

   // Next-state, datapath and counter updates.
   always_comb begin
      state_d       = state_q;
      word_d        = word_q;
      chk_d         = chk_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      tx_byte_d     = tx_byte_q;
      frames_sent_d = frames_sent_q;
      tx_error_d    = tx_error_q;

      case (state_q)
         S_IDLE: begin
            // uart must be idle too, so a reset mid-byte never kicks it early
            if (enable && !fifo_empty && !is_transmitting) begin
               state_d = S_POP;
            end
         end
         S_POP: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            word_d  = fifo_dout;
            chk_d   = HEADER ^ fifo_dout[15:8] ^ fifo_dout[7:0];
            idx_d   = 2'd0;
            state_d = S_KICK;
         end
         S_KICK: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (is_transmitting) begin
               state_d = S_WAIT_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_d == TIMEOUT_VAL) begin
                  tx_error_d = 1'b1;
                  state_d    = S_KICK;
               end
            end
         end
         S_WAIT_DONE: begin
            if (!is_transmitting) begin
               if (idx_q == 2'd3) begin
                  frames_sent_d = frames_sent_q + 16'd1;
                  state_d       = S_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_KICK;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // tx_byte only moves on entry to KICK, so it is stable for the whole byte
      if (state_d == S_KICK && state_q != S_KICK) begin
         tx_byte_d = sel_byte(idx_d, word_d, chk_d);
      end
   end

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         word_q        <= '0;
         chk_q         <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         tx_byte_q     <= '0;
         frames_sent_q <= '0;
         tx_error_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_q        <= word_d;
         chk_q         <= chk_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         tx_byte_q     <= tx_byte_d;
         frames_sent_q <= frames_sent_d;
         tx_error_q    <= tx_error_d;
      end
   end

   assign fifo_rd_en  = (state_q == S_POP);
   assign transmit    = (state_q == S_KICK);
   assign busy        = (state_q != S_IDLE);
   assign tx_byte     = tx_byte_q;
   assign frames_sent = frames_sent_q;
   assign tx_error    = tx_error_q;

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: FIFO and uart models, a table of frames with
// hand-computed bytes, and directed sequences for gating, timeout, reset, wrap.
module tb_uart_word_sender;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        fifo_rd_en;
   logic [15:0] fifo_dout = 16'h0;
   logic        transmit;
   logic [7:0]  tx_byte;
   logic        is_transmitting = 1'b0;
   logic        busy;
   logic [15:0] frames_sent;
   logic        tx_error;

   always #5 clk = ~clk;

   uart_word_sender #(.HEADER(8'h80), .BUSY_TIMEOUT(15)) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .fifo_empty      (fifo_empty),
      .fifo_rd_en      (fifo_rd_en),
      .fifo_dout       (fifo_dout),
      .transmit        (transmit),
      .tx_byte         (tx_byte),
      .is_transmitting (is_transmitting),
      .busy            (busy),
      .frames_sent     (frames_sent),
      .tx_error        (tx_error)
   );

   typedef struct {
      logic [15:0]      word;
      logic [3:0][7:0]  bytes;   // bytes[3] goes out first
   } vec_t;

   vec_t vecs[5];

   int checks = 0;
   int errors = 0;

   logic [15:0] fifo_q[$];
   logic [7:0]  sent[$];
   int          kick_cyc[$];
   int          gaps[$];
   int          cyc = 0, pops = 0, kick_n = 0, consec_err = 0, stab_err = 0;
   int          busy_cnt = 0, busy_len = 10, ignore_n = 0, idle_run = 0;
   bit          hold_busy = 1'b0, prev_tx = 1'b0, cur_valid = 1'b0;
   logic [7:0]  cur_byte = 8'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // FIFO, uart and protocol monitor, all evaluated on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (transmit && prev_tx) consec_err++;
      prev_tx = transmit;
      if (transmit) begin
         kick_n++;
         kick_cyc.push_back(cyc);
      end
      if (fifo_rd_en) begin
         pops++;
         if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
      if (!rst) cur_valid = 1'b0;
      else if (is_transmitting && cur_valid && tx_byte != cur_byte) stab_err++;
      if (!is_transmitting) begin
         if (transmit) begin
            if (ignore_n > 0) ignore_n--;
            else begin
               is_transmitting = 1'b1;
               busy_cnt  = busy_len;
               cur_byte  = tx_byte;
               cur_valid = 1'b1;
               sent.push_back(tx_byte);
            end
         end
      end else if (!hold_busy) begin
         busy_cnt--;
         if (busy_cnt <= 0) is_transmitting = 1'b0;
      end
      if (busy) begin
         if (idle_run > 0) gaps.push_back(idle_run);
         idle_run = 0;
      end else begin
         idle_run++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_frames(input logic [15:0] target, input string name);
      for (int i = 0; i < 3000 && frames_sent !== target; i++) tick(1);
      check(name, 32'(frames_sent), 32'(target));
   endtask

   task automatic wait_sent(input int n, input string name);
      for (int i = 0; i < 1000 && sent.size() < n; i++) tick(1);
      check(name, 32'(sent.size() >= n), 32'd1);
   endtask

   task automatic wait_kicks(input int n, input string name);
      for (int i = 0; i < 1000 && kick_n < n; i++) tick(1);
      check(name, 32'(kick_n >= n), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},        32'(busy),        32'd0);
      check({tag, "_fifo_rd_en"},  32'(fifo_rd_en),  32'd0);
      check({tag, "_transmit"},    32'(transmit),    32'd0);
      check({tag, "_tx_byte"},     32'(tx_byte),     32'd0);
      check({tag, "_frames_sent"}, 32'(frames_sent), 32'd0);
      check({tag, "_tx_error"},    32'(tx_error),    32'd0);
   endtask

   initial begin
      int k0, p0, s0;

      vecs[0].word = 16'h1234; vecs[0].bytes = {8'h80, 8'h12, 8'h34, 8'hA6};
      vecs[1].word = 16'hFFFF; vecs[1].bytes = {8'h80, 8'hFF, 8'hFF, 8'h80};
      vecs[2].word = 16'h0000; vecs[2].bytes = {8'h80, 8'h00, 8'h00, 8'h80};
      vecs[3].word = 16'hA55A; vecs[3].bytes = {8'h80, 8'hA5, 8'h5A, 8'h7F};
      vecs[4].word = 16'h0001; vecs[4].bytes = {8'h80, 8'h00, 8'h01, 8'h81};

      // Reset state
      #2 rst = 1'b0;
      #1 check_idle_outputs("reset");
      tick(3);
      check_idle_outputs("reset_clocked");
      @(negedge clk);
      rst = 1'b1;
      tick(2);

      // Single word, then four back-to-back frames
      sent.delete();
      fifo_q.push_back(vecs[0].word);
      enable = 1'b1;
      wait_frames(16'd1, "single_frames_sent");
      check("single_busy_after", 32'(busy), 32'd0);
      check("single_pops", 32'(pops), 32'd1);
      check("single_kicks", 32'(kick_n), 32'd4);

      gaps.delete();
      for (int v = 1; v < 5; v++) fifo_q.push_back(vecs[v].word);
      wait_frames(16'd5, "b2b_frames_sent");
      check("b2b_pops", 32'(pops), 32'd5);
      check("b2b_kicks", 32'(kick_n), 32'd20);
      check("b2b_gap_count", 32'(gaps.size()), 32'd4);
      for (int g = 1; g < 4; g++)
         check($sformatf("b2b_idle_gap%0d", g), 32'(gaps[g]), 32'd1);
      check("bytes_total", 32'(sent.size()), 32'd20);
      for (int v = 0; v < 5; v++)
         for (int k = 0; k < 4; k++)
            check($sformatf("vec%0d_byte%0d", v, k), 32'(sent[4*v+k]), 32'(vecs[v].bytes[3-k]));

      // Enable gating
      enable = 1'b0;
      fifo_q.push_back(16'hA55A);
      fifo_q.push_back(16'h0001);
      tick(100);
      check("gate_no_pop", 32'(pops), 32'd5);
      check("gate_idle", 32'(busy), 32'd0);
      enable = 1'b1;
      wait_sent(22, "gate_reach_byte2");
      enable = 1'b0;
      wait_frames(16'd6, "gate_frame_completes");
      tick(100);
      check("gate_frames_after", 32'(frames_sent), 32'd6);
      check("gate_single_pop", 32'(pops), 32'd6);
      check("gate_fifo_left", 32'(fifo_q.size()), 32'd1);
      check("gate_chk_byte", 32'(sent[23]), 32'h7F);
      fifo_q.delete();
      tick(2);

      // Busy timeout and retry of the same byte
      ignore_n = 1;
      k0 = kick_n;
      fifo_q.push_back(16'h1234);
      enable = 1'b1;
      wait_kicks(k0 + 1, "to_first_kick");
      check("to_err_before", 32'(tx_error), 32'd0);
      wait_kicks(k0 + 2, "to_second_kick");
      check("to_err_set", 32'(tx_error), 32'd1);
      check("to_retry_spacing", 32'(kick_cyc[k0+1] - kick_cyc[k0]), 32'd16);
      wait_frames(16'd7, "to_frame_completes");
      enable = 1'b0;
      check("to_bytes_total", 32'(sent.size()), 32'd28);
      check("to_retry_byte", 32'(sent[24]), 32'h80);
      check("to_byte1", 32'(sent[25]), 32'h12);
      check("to_byte2", 32'(sent[26]), 32'h34);
      check("to_byte3", 32'(sent[27]), 32'hA6);
      check("to_err_sticky", 32'(tx_error), 32'd1);

      // Reset during WAIT_DONE of byte 1, uart still shifting afterwards
      s0 = sent.size();
      fifo_q.push_back(16'hBEEF);
      enable = 1'b1;
      wait_sent(s0 + 2, "rst_reach_byte1");
      tick(3);
      hold_busy = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
      #1 check_idle_outputs("async_reset");
      tick(2);
      @(negedge clk);
      rst = 1'b1;
      fifo_q.push_back(16'h1234);
      p0 = pops;
      tick(30);
      check("rst_no_pop_while_uart_busy", 32'(pops), 32'(p0));
      check("rst_idle_while_uart_busy", 32'(busy), 32'd0);
      hold_busy = 1'b0;
      wait_frames(16'd1, "rst_frame_after_release");
      check("rst_one_pop", 32'(pops), 32'(p0 + 1));
      enable = 1'b0;
      tick(2);

      // Frame counter wrap
      @(negedge clk);
      force dut.frames_sent_d = 16'hFFFF;
      @(negedge clk);
      release dut.frames_sent_d;
      #1 check("wrap_preload", 32'(frames_sent), 32'hFFFF);
      fifo_q.push_back(16'h0001);
      enable = 1'b1;
      wait_frames(16'h0000, "wrap_to_zero");
      check("wrap_busy_after", 32'(busy), 32'd0);
      check("wrap_chk_byte", 32'(sent[sent.size()-1]), 32'h81);
      enable = 1'b0;
      tick(5);

      check("transmit_never_consecutive", 32'(consec_err), 32'd0);
      check("tx_byte_stable_while_busy", 32'(stab_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
